// File: rtl/mux4b_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit 2:1 mux between two requesters,
// with a single-entry output register drained by a valid/ready consumer.
module mux4b_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  input  logic             req2,
  input  logic [WIDTH-1:0] data2,
  output logic             ack2,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             last_grant
);

  // Handshake: a word moves downstream on any rising edge where out_valid and
  // out_ready are both high; out_data/out_valid never change while the word is
  // stalled. Upstream, reqN holds with stable dataN until the one-cycle ackN.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             grant_q, grant_d;

  logic             any_req;
  logic             win2;
  logic             mux_sel;
  logic [WIDTH-1:0] mux_out;
  logic             can_capture;
  logic             capture;

  always_comb begin
    any_req     = req1 | req2;
    // On a tie, requester 2 wins only when requester 1 was granted last.
    win2        = req2 & (~req1 | ~grant_q);
    mux_sel     = any_req ? win2 : grant_q;
    mux_out     = mux_sel ? data2 : data1;
    can_capture = (state_q == ST_EMPTY) | out_ready;
    capture     = can_capture & any_req & ~rst;

    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (capture) begin
      state_d = ST_FULL;
      data_d  = mux_out;
      grant_d = win2;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // grant_q resets to requester 2 so requester 1 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign ack1       = capture & ~win2;
  assign ack2       = capture & win2;
  assign sel        = mux_sel & ~rst;
  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = data_q;
  assign last_grant = grant_q;

endmodule

// File: tb/tb_mux4b_arbiter.sv
// Directed and random stimulus for mux4b_arbiter; captured words are tracked
// in an expected queue and compared as the consumer takes them.
module tb_mux4b_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req1, req2, out_ready;
  logic [W-1:0] data1, data2;
  logic         ack1, ack2, sel, out_valid, last_grant;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic         m_valid, m_last;
  logic [W-1:0] m_data;
  logic         exp_ack1, exp_ack2, exp_sel;

  always #5 clk = ~clk;

  mux4b_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req1(req1), .data1(data1), .ack1(ack1),
    .req2(req2), .data2(data2), .ack2(ack2),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .last_grant(last_grant)
  );

  // Scoreboard: every word taken by the consumer must match the oldest expected one.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: consumed %h with no word expected", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) $display("FAIL sb_data: got %h want %h", out_data, mon_exp);
        else n_pass++;
      end
    end
  end

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b1;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs after the falling edge and predict the outcome.
  task automatic drive(input logic r1, input logic [W-1:0] d1,
                       input logic r2, input logic [W-1:0] d2, input logic rdy);
    logic cap, w2;
    @(negedge clk);
    req1 = r1; data1 = d1; req2 = r2; data2 = d2; out_ready = rdy;
    cap = (!m_valid || rdy) && (r1 || r2);
    w2  = r2 && (!r1 || !m_last);
    exp_ack1 = cap && !w2;
    exp_ack2 = cap && w2;
    exp_sel  = (r1 || r2) ? w2 : m_last;
    if (cap) begin
      exp_q.push_back(w2 ? d2 : d1);
      m_valid = 1'b1;
      m_data  = w2 ? d2 : d1;
      m_last  = w2;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; data1 = '0; data2 = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 4'h0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (last_grant !== 1'b1) $display("FAIL reset_last_grant: got %b want 1", last_grant); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL reset_sel: got %b want 0", sel); else n_pass++;
    n_checks++; if ({ack1, ack2} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {ack1, ack2}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (sel !== 1'b1) $display("FAIL idle_sel: got %b want 1", sel); else n_pass++;
  endtask

  task automatic test_single();
    drive(1'b1, 4'b1010, 1'b0, 4'h0, 1'b1);
    n_checks++; if (ack1 !== 1'b1) $display("FAIL single_ack1: got %b want 1", ack1); else n_pass++;
    n_checks++; if (ack2 !== 1'b0) $display("FAIL single_ack2: got %b want 0", ack2); else n_pass++;
    n_checks++; if (sel !== 1'b0) $display("FAIL single_sel: got %b want 0", sel); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 4'b1010) $display("FAIL single_data: got %h want a", out_data); else n_pass++;
    n_checks++; if (last_grant !== 1'b0) $display("FAIL single_last_grant: got %b want 0", last_grant); else n_pass++;
  endtask

  task automatic test_consume_empty();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    n_checks++; if (sel !== 1'b0) $display("FAIL consume_sel: got %b want 0", sel); else n_pass++;
    n_checks++; if ({ack1, ack2} !== 2'b00) $display("FAIL consume_ack: got %b want 00", {ack1, ack2}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL consume_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 4'b1010) $display("FAIL consume_data: got %h want a", out_data); else n_pass++;
  endtask

  task automatic test_tie();
    logic [W-1:0] td[3];
    logic         ta1[3];
    td[0] = 4'b0011; td[1] = 4'b1100; td[2] = 4'b0011;
    ta1[0] = 1'b1;   ta1[1] = 1'b0;   ta1[2] = 1'b1;
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0011, 1'b1, 4'b1100, 1'b1);
      n_checks++; if (ack1 !== ta1[i]) $display("FAIL tie_ack1[%0d]: got %b want %b", i, ack1, ta1[i]); else n_pass++;
      n_checks++; if (ack2 !== !ta1[i]) $display("FAIL tie_ack2[%0d]: got %b want %b", i, ack2, !ta1[i]); else n_pass++;
      n_checks++; if (sel !== !ta1[i]) $display("FAIL tie_sel[%0d]: got %b want %b", i, sel, !ta1[i]); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (out_data !== td[i]) $display("FAIL tie_data[%0d]: got %h want %h", i, out_data, td[i]); else n_pass++;
      n_checks++; if (last_grant !== !ta1[i]) $display("FAIL tie_last_grant[%0d]: got %b want %b", i, last_grant, !ta1[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    drive(1'b1, 4'b0101, 1'b0, 4'h0, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (out_data !== 4'b0101) $display("FAIL bp_fill: got %h want 5", out_data); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'b1, 4'b1001, 1'b0);
      n_checks++; if ({ack1, ack2} !== 2'b00) $display("FAIL bp_ack[%0d]: got %b want 00", i, {ack1, ack2}); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 4'b0101 || last_grant !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h g=%b want v=1 d=5 g=0", i, out_valid, out_data, last_grant);
      else n_pass++;
    end
    drive(1'b0, 4'h0, 1'b1, 4'b1001, 1'b1);
    n_checks++; if (ack2 !== 1'b1) $display("FAIL bp_release_ack2: got %b want 1", ack2); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_data !== 4'b1001 || last_grant !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL bp_release: got v=%b d=%h g=%b want v=1 d=9 g=1", out_valid, out_data, last_grant);
    else n_pass++;
  endtask

  task automatic test_withdrawn();
    drive(1'b1, 4'b0110, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    drive(1'b1, 4'b0111, 1'b0, 4'h0, 1'b0);
    n_checks++; if (ack1 !== 1'b0) $display("FAIL wd_stall_ack1: got %b want 0", ack1); else n_pass++;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    n_checks++; if ({ack1, ack2} !== 2'b00) $display("FAIL wd_ack: got %b want 00", {ack1, ack2}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 4'b0110)
      $display("FAIL wd_drain: got v=%b d=%h want v=0 d=6", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'b1111, 1'b0, 4'h0, 1'b1);
    drive(1'b1, 4'b1110, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 4'h0 || last_grant !== 1'b1)
      $display("FAIL mid_reset_state: got v=%b d=%h g=%b want v=0 d=0 g=1", out_valid, out_data, last_grant);
    else n_pass++;
    n_checks++; if (ack1 !== 1'b0 || sel !== 1'b0)
      $display("FAIL mid_reset_outputs: got ack1=%b sel=%b want 0 0", ack1, sel);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      n_checks++; if ({ack1, ack2} !== 2'b00) $display("FAIL mid_idle_ack[%0d]: got %b want 00", i, {ack1, ack2}); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_idle_valid[%0d]: got %b want 0", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic r1, r2, rdy;
    logic [W-1:0] d1, d2;
    for (int i = 0; i < 60; i++) begin
      r1  = ($urandom_range(0, 2) != 0);
      r2  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      d1  = W'($urandom_range(0, 15));
      d2  = W'($urandom_range(0, 15));
      drive(r1, d1, r2, d2, rdy);
      n_checks++; if ({ack1, ack2, sel} !== {exp_ack1, exp_ack2, exp_sel})
        $display("FAIL b2b_comb[%0d]: got ack1/ack2/sel=%b want %b", i, {ack1, ack2, sel}, {exp_ack1, exp_ack2, exp_sel});
      else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== m_valid || last_grant !== m_last || (m_valid && out_data !== m_data))
        $display("FAIL b2b_state[%0d]: got v=%b g=%b d=%h want v=%b g=%b d=%h", i, out_valid, last_grant, out_data, m_valid, m_last, m_data);
      else n_pass++;
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    @(posedge clk); #1;
    n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain: got %0d words pending, v=%b want 0 pending, v=0", exp_q.size(), out_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_consume_empty();
    test_tie();
    test_backpressure();
    test_consume_empty_after_bp();
    test_withdrawn();
    test_reset_midstream();
    test_back_to_back();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic test_consume_empty_after_bp();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    n_checks++; if (sel !== 1'b1) $display("FAIL consume2_sel: got %b want 1", sel); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 4'b1001)
      $display("FAIL consume2_state: got v=%b d=%h want v=0 d=9", out_valid, out_data);
    else n_pass++;
  endtask

endmodule
